// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, instruction
// classes, opcodes, ALU function codes and PC source selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIf    = 4'd0,
        StId    = 4'd1,
        StExeAl = 4'd2,
        StWbAl  = 4'd3,
        StExeBr = 4'd4,
        StExeLs = 4'd5,
        StMem   = 4'd6,
        StWbLd  = 4'd7,
        StHalt  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsBranch,
        ClsMem,
        ClsJump,
        ClsHalt,
        ClsIllegal
    } instr_cls_e;

    localparam logic [5:0] OpAdd  = 6'b000000;
    localparam logic [5:0] OpSub  = 6'b000001;
    localparam logic [5:0] OpAddi = 6'b000010;
    localparam logic [5:0] OpOr   = 6'b010000;
    localparam logic [5:0] OpAnd  = 6'b010001;
    localparam logic [5:0] OpOri  = 6'b010010;
    localparam logic [5:0] OpSll  = 6'b011000;
    localparam logic [5:0] OpSlt  = 6'b100110;
    localparam logic [5:0] OpSw   = 6'b110000;
    localparam logic [5:0] OpLw   = 6'b110001;
    localparam logic [5:0] OpBeq  = 6'b110100;
    localparam logic [5:0] OpBne  = 6'b110101;
    localparam logic [5:0] OpJ    = 6'b111000;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluOr  = 3'b010;
    localparam logic [2:0] AluAnd = 3'b011;
    localparam logic [2:0] AluSll = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] PcSrcSeq    = 2'b00;
    localparam logic [1:0] PcSrcBranch = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Purely combinational opcode decoder: instruction class plus the controls that
// depend only on the opcode, not on the FSM state.
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic [5:0]  opcode_i,
    output instr_cls_e  cls_o,
    output logic        is_lw_o,
    output logic        is_beq_o,
    output logic        reg_out_o,
    output logic        alu_src_b_o,
    output logic        ext_sel_o,
    output logic [2:0]  alu_op_o
);

    // Opcode table; anything unlisted decodes as illegal with benign controls.
    always_comb begin
        cls_o       = ClsIllegal;
        is_lw_o     = 1'b0;
        is_beq_o    = 1'b0;
        reg_out_o   = 1'b0;
        alu_src_b_o = 1'b0;
        ext_sel_o   = 1'b1;
        alu_op_o    = AluAdd;
        // Halt is checked first so an overlapping HALT_OP still parks the FSM.
        if (opcode_i == HALT_OP) begin
            cls_o = ClsHalt;
        end else begin
            case (opcode_i)
                OpAdd:  begin cls_o = ClsAlu; reg_out_o = 1'b1; end
                OpSub:  begin cls_o = ClsAlu; reg_out_o = 1'b1; alu_op_o = AluSub; end
                OpAddi: begin cls_o = ClsAlu; alu_src_b_o = 1'b1; end
                OpOr:   begin cls_o = ClsAlu; reg_out_o = 1'b1; alu_op_o = AluOr; end
                OpAnd:  begin cls_o = ClsAlu; reg_out_o = 1'b1; alu_op_o = AluAnd; end
                OpOri:  begin
                    cls_o       = ClsAlu;
                    alu_src_b_o = 1'b1;
                    ext_sel_o   = 1'b0;
                    alu_op_o    = AluOr;
                end
                OpSll:  begin cls_o = ClsAlu; reg_out_o = 1'b1; alu_op_o = AluSll; end
                OpSlt:  begin cls_o = ClsAlu; reg_out_o = 1'b1; alu_op_o = AluSlt; end
                OpSw:   begin cls_o = ClsMem; alu_src_b_o = 1'b1; end
                OpLw:   begin cls_o = ClsMem; alu_src_b_o = 1'b1; is_lw_o = 1'b1; end
                OpBeq:  begin cls_o = ClsBranch; is_beq_o = 1'b1; alu_op_o = AluSub; end
                OpBne:  begin cls_o = ClsBranch; alu_op_o = AluSub; end
                OpJ:    cls_o = ClsJump;
                default: cls_o = ClsIllegal;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: sequences each instruction through IF/ID/EXE/MEM/WB,
// gates the write enables per state, counts retired instructions and records
// illegal opcodes.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    output logic             pc_wre_o,
    output logic             ir_wre_o,
    output logic             reg_wre_o,
    output logic             reg_out_o,
    output logic             alum2reg_o,
    output logic             alu_src_b_o,
    output logic             ext_sel_o,
    output logic [2:0]       alu_op_o,
    output logic             m_rd_o,
    output logic             m_wr_o,
    output logic [1:0]       pc_src_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired_o,
    output logic             illegal_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    instr_cls_e cls;
    logic       is_lw;
    logic       is_beq;
    logic       is_bne;

    mc_decode #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .opcode_i    (opcode_i),
        .cls_o       (cls),
        .is_lw_o     (is_lw),
        .is_beq_o    (is_beq),
        .reg_out_o   (reg_out_o),
        .alu_src_b_o (alu_src_b_o),
        .ext_sel_o   (ext_sel_o),
        .alu_op_o    (alu_op_o)
    );

    assign is_bne = (cls == ClsBranch) && !is_beq;

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIf:    state_d = StId;
            StId: begin
                case (cls)
                    ClsAlu:    state_d = StExeAl;
                    ClsBranch: state_d = StExeBr;
                    ClsMem:    state_d = StExeLs;
                    ClsHalt:   state_d = StHalt;
                    default:   state_d = StIf;
                endcase
            end
            StExeAl: state_d = StWbAl;
            StWbAl:  state_d = StIf;
            StExeBr: state_d = StIf;
            StExeLs: state_d = StMem;
            StMem:   state_d = is_lw ? StWbLd : StIf;
            StWbLd:  state_d = StIf;
            StHalt:  state_d = StHalt;
            default: state_d = StIf;
        endcase
    end

    // Per-state enables; all forced low while reset is asserted so an aborted
    // instruction never writes anything.
    always_comb begin
        pc_wre_o   = 1'b0;
        ir_wre_o   = 1'b0;
        reg_wre_o  = 1'b0;
        alum2reg_o = 1'b0;
        m_rd_o     = 1'b0;
        m_wr_o     = 1'b0;
        if (!reset_i) begin
            case (state_q)
                StIf:    ir_wre_o = 1'b1;
                StId:    pc_wre_o = (cls == ClsJump) || (cls == ClsIllegal);
                StWbAl: begin
                    reg_wre_o = 1'b1;
                    pc_wre_o  = 1'b1;
                end
                StExeBr: pc_wre_o = 1'b1;
                StMem: begin
                    m_rd_o   = (cls == ClsMem) && is_lw;
                    m_wr_o   = (cls == ClsMem) && !is_lw;
                    pc_wre_o = !is_lw;
                end
                StWbLd: begin
                    reg_wre_o  = 1'b1;
                    alum2reg_o = 1'b1;
                    pc_wre_o   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // PC source follows the opcode; branch target only when the condition holds.
    always_comb begin
        pc_src_o = PcSrcSeq;
        if (cls == ClsJump) begin
            pc_src_o = PcSrcJump;
        end else if ((is_beq && zero_i) || (is_bne && !zero_i)) begin
            pc_src_o = PcSrcBranch;
        end
    end

    // Counter and sticky flag next-state.
    always_comb begin
        retired_d = retired_q;
        if (pc_wre_o) begin
            retired_d = retired_q + CNT_W'(1);
        end
        illegal_d = illegal_q || ((state_q == StId) && (cls == ClsIllegal));
    end

    // State, counter and flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StIf;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed scenarios plus randomized
// instruction streams checked against a cycle-count based reference model.
module tb_mc_control_unit;

    localparam int unsigned CW = 4;  // small counter so wrap-around is exercised

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b101010;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [5:0]    opcode = OP_ADD;
    logic          zero = 1'b0;
    logic          pc_wre, ir_wre, reg_wre, reg_out, alum2reg, alu_src_b, ext_sel;
    logic [2:0]    alu_op;
    logic          m_rd, m_wr;
    logic [1:0]    pc_src;
    logic [3:0]    state;
    logic [CW-1:0] retired;
    logic          illegal;
    logic [13:0]   ctl_obs;
    logic [4:0]    en_obs;

    int checks = 0;
    int errors = 0;

    logic [5:0] pool [13] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL,
                              OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_J};

    always #5 clk = ~clk;

    mc_control_unit #(
        .CNT_W   (CW),
        .HALT_OP (OP_HALT)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .opcode_i    (opcode),
        .zero_i      (zero),
        .pc_wre_o    (pc_wre),
        .ir_wre_o    (ir_wre),
        .reg_wre_o   (reg_wre),
        .reg_out_o   (reg_out),
        .alum2reg_o  (alum2reg),
        .alu_src_b_o (alu_src_b),
        .ext_sel_o   (ext_sel),
        .alu_op_o    (alu_op),
        .m_rd_o      (m_rd),
        .m_wr_o      (m_wr),
        .pc_src_o    (pc_src),
        .state_o     (state),
        .retired_o   (retired),
        .illegal_o   (illegal)
    );

    assign ctl_obs = {pc_wre, ir_wre, reg_wre, reg_out, alum2reg, alu_src_b, ext_sel,
                      alu_op, m_rd, m_wr, pc_src};
    assign en_obs  = {pc_wre, ir_wre, reg_wre, m_rd, m_wr};

    // Drive one cycle's inputs after the falling edge and let outputs settle.
    task automatic tick(input logic r, input logic [5:0] op, input logic z);
        @(negedge clk);
        reset_i = r;
        opcode  = op;
        zero    = z;
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_rd(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT};
    endfunction

    // Total cycles an instruction occupies.
    function automatic int op_len(input logic [5:0] op);
        if (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT})
            return 4;
        if (op == OP_LW) return 5;
        if (op == OP_SW) return 4;
        if (op == OP_BEQ || op == OP_BNE) return 3;
        return 2;
    endfunction

    // State visited at cycle k of an instruction.
    function automatic logic [3:0] exp_state(input logic [5:0] op, input int k);
        if (k == 0) return 4'd0;
        if (k == 1) return 4'd1;
        if (op == OP_LW) return (k == 2) ? 4'd5 : (k == 3) ? 4'd6 : 4'd7;
        if (op == OP_SW) return (k == 2) ? 4'd5 : 4'd6;
        if (op == OP_BEQ || op == OP_BNE) return 4'd4;
        if (op == OP_HALT) return 4'd8;
        return (k == 2) ? 4'd2 : 4'd3;
    endfunction

    function automatic logic [13:0] exp_ctl(input logic [5:0] op, input logic [3:0] st,
                                            input logic z, input bit last);
        logic [2:0] aop;
        logic [1:0] src;
        aop = 3'b000;
        if (op inside {OP_SUB, OP_BEQ, OP_BNE}) aop = 3'b001;
        if (op inside {OP_OR, OP_ORI}) aop = 3'b010;
        if (op == OP_AND) aop = 3'b011;
        if (op == OP_SLL) aop = 3'b100;
        if (op == OP_SLT) aop = 3'b101;
        src = 2'b00;
        if (op == OP_J) src = 2'b10;
        else if ((op == OP_BEQ && z) || (op == OP_BNE && !z)) src = 2'b01;
        return {last, st == 4'd0, st == 4'd3 || st == 4'd7, is_rd(op), st == 4'd7,
                op inside {OP_ADDI, OP_ORI, OP_LW, OP_SW}, op != OP_ORI, aop,
                st == 4'd6 && op == OP_LW, st == 4'd6 && op == OP_SW, src};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, OP_ADD, 1'b0);
            checks++;
            if (state !== 4'd0 || en_obs !== 5'b0 || retired !== '0 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset: state=%0d en=%b retired=%0d illegal=%b, want 0 00000 0 0",
                         state, en_obs, retired, illegal);
            end
        end
    endtask

    task automatic test_alu;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, OP_ADD, 1'b0);
            checks++;
            if (state !== 4'(k)) begin
                errors++;
                $display("FAIL add_state k=%0d: got %0d want %0d", k, state, k);
            end
            checks++;
            if ({reg_wre, reg_out, alum2reg, pc_wre} !== {k == 3, 1'b1, 1'b0, k == 3}) begin
                errors++;
                $display("FAIL add_ctl k=%0d: got %b want %b", k,
                         {reg_wre, reg_out, alum2reg, pc_wre}, {k == 3, 1'b1, 1'b0, k == 3});
            end
        end
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (retired !== 4'd1 || state !== 4'd0) begin
            errors++;
            $display("FAIL add_retire: retired=%0d state=%0d want 1 0", retired, state);
        end
    endtask

    task automatic test_load_store;
        logic [3:0] lw_seq [5];
        logic [3:0] sw_seq [4];
        lw_seq = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
        sw_seq = '{4'd0, 4'd1, 4'd5, 4'd6};
        tick(1'b1, OP_LW, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, OP_LW, 1'b0);
            checks++;
            if (state !== lw_seq[k] ||
                {m_rd, m_wr, reg_wre, alum2reg, reg_out, pc_wre} !==
                {k == 3, 1'b0, k == 4, k == 4, 1'b0, k == 4}) begin
                errors++;
                $display("FAIL lw k=%0d: state=%0d ctl=%b want state=%0d ctl=%b", k, state,
                         {m_rd, m_wr, reg_wre, alum2reg, reg_out, pc_wre}, lw_seq[k],
                         {k == 3, 1'b0, k == 4, k == 4, 1'b0, k == 4});
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, OP_SW, 1'b0);
            checks++;
            if (state !== sw_seq[k] ||
                {m_rd, m_wr, reg_wre, pc_wre} !== {1'b0, k == 3, 1'b0, k == 3}) begin
                errors++;
                $display("FAIL sw k=%0d: state=%0d ctl=%b want state=%0d ctl=%b", k, state,
                         {m_rd, m_wr, reg_wre, pc_wre}, sw_seq[k], {1'b0, k == 3, 1'b0, k == 3});
            end
        end
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (retired !== 4'd2) begin
            errors++;
            $display("FAIL ls_retire: got %0d want 2", retired);
        end
    endtask

    task automatic test_branch;
        logic [5:0] op;
        logic       z;
        logic [1:0] want_src;
        tick(1'b1, OP_BEQ, 1'b0);
        for (int i = 0; i < 4; i++) begin
            op = (i < 2) ? OP_BEQ : OP_BNE;
            z  = (i % 2 == 1);
            want_src = ((op == OP_BEQ) == z) ? 2'b01 : 2'b00;
            for (int k = 0; k < 3; k++) begin
                tick(1'b0, op, z);
                checks++;
                if (state !== ((k == 2) ? 4'd4 : 4'(k))) begin
                    errors++;
                    $display("FAIL br_state op=%b k=%0d: got %0d", op, k, state);
                end
                if (k == 2) begin
                    checks++;
                    if ({pc_wre, pc_src} !== {1'b1, want_src}) begin
                        errors++;
                        $display("FAIL br_pc op=%b zero=%b: got %b want %b", op, z,
                                 {pc_wre, pc_src}, {1'b1, want_src});
                    end
                end
            end
        end
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (retired !== 4'd4) begin
            errors++;
            $display("FAIL br_retire: got %0d want 4", retired);
        end
    endtask

    task automatic test_jump_illegal;
        tick(1'b1, OP_J, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, OP_J, 1'b0);
            checks++;
            if (state !== 4'(k) || (k == 1 && {pc_wre, pc_src} !== 3'b110)) begin
                errors++;
                $display("FAIL jump k=%0d: state=%0d pc=%b want state=%0d pc=110", k, state,
                         {pc_wre, pc_src}, k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, OP_BAD, 1'b1);
            checks++;
            if (state !== 4'(k) || (k == 1 && {pc_wre, pc_src} !== 3'b100)) begin
                errors++;
                $display("FAIL illegal_op k=%0d: state=%0d pc=%b want state=%0d pc=100", k,
                         state, {pc_wre, pc_src}, k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, OP_ADD, 1'b0);
            checks++;
            if (state !== 4'(k) || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_sticky k=%0d: state=%0d illegal=%b want %0d 1", k,
                         state, illegal, k);
            end
        end
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (retired !== 4'd3) begin
            errors++;
            $display("FAIL ji_retire: got %0d want 3", retired);
        end
    endtask

    task automatic test_random;
        logic [5:0] op;
        logic       z;
        logic [3:0] st;
        bit         last;
        int         ret;
        logic       ill;
        int         n;
        tick(1'b1, OP_ADD, 1'b0);
        ret = 0;
        ill = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (op == OP_HALT) op = 6'($urandom_range(0, 63));
            end else begin
                op = pool[$urandom_range(0, 12)];
            end
            n = op_len(op);
            for (int k = 0; k < n; k++) begin
                z = 1'($urandom_range(0, 1));
                tick(1'b0, op, z);
                st   = exp_state(op, k);
                last = (k == n - 1);
                checks++;
                if (state !== st) begin
                    errors++;
                    $display("FAIL rnd_state op=%b k=%0d: got %0d want %0d", op, k, state, st);
                end
                checks++;
                if (ctl_obs !== exp_ctl(op, st, z, last)) begin
                    errors++;
                    $display("FAIL rnd_ctl op=%b k=%0d zero=%b: got %b want %b", op, k, z,
                             ctl_obs, exp_ctl(op, st, z, last));
                end
                checks++;
                if (retired !== CW'(ret % (1 << CW)) || illegal !== ill) begin
                    errors++;
                    $display("FAIL rnd_count op=%b k=%0d: retired=%0d illegal=%b want %0d %b",
                             op, k, retired, illegal, ret % (1 << CW), ill);
                end
                if (last) ret++;
                if (k == 1 && op_len(op) == 2 && op != OP_J) ill = 1'b1;
            end
        end
    endtask

    task automatic test_halt;
        tick(1'b1, OP_BAD, 1'b0);
        tick(1'b0, OP_BAD, 1'b0);
        tick(1'b0, OP_BAD, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, OP_HALT, 1'b0);
            checks++;
            if (state !== 4'(k) || pc_wre !== 1'b0) begin
                errors++;
                $display("FAIL halt_entry k=%0d: state=%0d pc_wre=%b want %0d 0", k, state,
                         pc_wre, k);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, OP_HALT, 1'($urandom_range(0, 1)));
            checks++;
            if (state !== 4'd8 || en_obs !== 5'b0 || retired !== 4'd1 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold c=%0d: state=%0d en=%b retired=%0d illegal=%b", c,
                         state, en_obs, retired, illegal);
            end
        end
        tick(1'b1, OP_HALT, 1'b0);
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (state !== 4'd0 || retired !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: state=%0d retired=%0d illegal=%b want 0 0 0", state,
                     retired, illegal);
        end
    endtask

    task automatic test_reset_mid;
        tick(1'b1, OP_ADD, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, OP_ADD, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b0, OP_LW, 1'b0);
        tick(1'b1, OP_LW, 1'b0);
        checks++;
        if (state !== 4'd7 || retired !== 4'd1 || {reg_wre, pc_wre} !== 2'b00) begin
            errors++;
            $display("FAIL reset_wbld: state=%0d retired=%0d wre=%b want 7 1 00", state,
                     retired, {reg_wre, pc_wre});
        end
        tick(1'b0, OP_ADD, 1'b0);
        checks++;
        if (state !== 4'd0 || retired !== 4'd0) begin
            errors++;
            $display("FAIL reset_wbld_after: state=%0d retired=%0d want 0 0", state, retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_jump_illegal();
        test_random();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM sitting directly upstream of the register file and datapath.
- Decodes the 6-bit opcode latched in IR and sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the register-file controls (RegWre, RegOut, ALUM2Reg) plus PC, IR, ALU and data-memory controls.
- Keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- HALT_OP, 6'b111111, opcode that parks the FSM in HALT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU result == 0
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- RegWre  out  1  register-file write enable
- RegOut  out  1  1 = write rd, 0 = write rt
- ALUM2Reg  out  1  1 = write data from memory, 0 = from ALU
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend
- ALUOp  out  3  ALU function code
- mRD  out  1  data-memory read
- mWR  out  1  data-memory write
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- state  out  4  current FSM state
- retired  out  CNT_W  count of completed instructions
- illegal  out  1  sticky: an unknown opcode was decoded

Behaviour:
- Reset (sync, takes priority over everything): state=IF, retired=0, illegal=0. Reset asserted mid-instruction aborts it; no write enable is asserted in the reset cycle.
- States (4-bit encoding): IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8.
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101
  - j 111000, halt = HALT_OP
- Transitions:
  - IF -> ID always.
  - From ID:
    - ALU ops -> EXE_AL; beq/bne -> EXE_BR; lw/sw -> EXE_LS.
    - j -> IF; halt -> HALT; unknown -> IF.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM. MEM -> WB_LD if lw, else IF (sw).
  - WB_LD -> IF.
  - HALT -> HALT until reset.
- Cycle counts: ALU ops 4, lw 5, sw 4, beq/bne 3, j 2, unknown 2.
- Outputs are combinational from state and opcode. Every enable defaults to 0.
  - IRWre=1 only in IF.
  - RegWre=1 only in WB_AL and WB_LD. ALUM2Reg=1 only in WB_LD.
  - RegOut=1 for add/sub/or/and/sll/slt; 0 for addi/ori/lw. Held stable in all states.
  - mRD=1 in MEM for lw. mWR=1 in MEM for sw. Never both.
  - PCWre=1 in the last state of each instruction: WB_AL, WB_LD, MEM(sw), EXE_BR, ID(j / unknown). Never in HALT.
- PCSrc:
  - 10 for j.
  - 01 for beq with zero=1, or bne with zero=0.
  - 00 otherwise, including unknown opcodes.
- ALUSrcB=1 for addi/ori/lw/sw.
- ExtSel=0 for ori, 1 otherwise.
- ALUOp (codes defined in package): ADD 000, SUB 001, OR 010, AND 011, SLL 100, SLT 101.
  - add/addi/lw/sw -> ADD; sub/beq/bne -> SUB.
- retired increments by 1 on every cycle with PCWre=1. It wraps modulo 2^CNT_W. Unknown opcodes count.
- illegal is set on the ID cycle that decodes an unknown opcode and is cleared only by reset.
- The opcode input is sampled every cycle. IR must stay stable outside IF; that is the datapath's responsibility.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants, ALUOp codes, PCSrc codes.
- One sub-module, mc_decode: purely combinational opcode -> instruction-class and static controls (RegOut, ALUSrcB, ExtSel, ALUOp).
- The top level holds the state register, counter, illegal flag and per-state enable gating.

Test Plan:
- Reset held 2 cycles, then add: state 0,1,2,3,0.
  - RegWre=1, RegOut=1, ALUM2Reg=0 only in cycle 4; retired=1.
- lw then sw:
  - lw: mRD=1 in MEM, RegWre=1 and ALUM2Reg=1 in WB_LD, RegOut=0.
  - sw: mWR=1 in MEM, RegWre never asserted.
  - retired=2 after 9 cycles.
- beq: zero=1 gives PCSrc=01 with PCWre in EXE_BR; zero=0 gives PCSrc=00. bne gives the inverse. 3 cycles each.
- j then opcode 101010:
  - j: PCSrc=10 and PCWre in ID, 2 cycles.
  - 101010: illegal=1, PCSrc=00, next state IF; illegal stays 1 afterwards.
- halt: FSM enters HALT(8) and stays 20 cycles with all enables 0 and retired frozen. reset then gives state=0, retired=0, illegal=0.
- reset asserted during WB_LD: RegWre=0 in that cycle, next state IF, retired=0.
